// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core load/store path and a host port.
// Optional build macro DMEM_ARB_HOST_PRIO_EN selects fixed host priority in place of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("dmem_arbiter: MEM_LAT must be >= 1");
  end

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, CORE_ACC, HOST_ACC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner_host;
  logic             last_host;
  logic             pick_host;

  // Host wins when it is the only requester, or on a tie the core won last time.
  always_comb begin
    pick_host = 1'b0;
`ifdef DMEM_ARB_HOST_PRIO_EN
    pick_host = host_req;
`else
    pick_host = host_req & ~(core_req & last_host);
`endif
  end

  assign core_stall = core_req & ~core_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_host <= 1'b0;
      last_host  <= 1'b1;
      core_rdata <= '0;
      core_done  <= 1'b0;
      host_gnt   <= 1'b0;
      host_rdata <= '0;
      host_done  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req || host_req) begin
            state      <= pick_host ? HOST_ACC : CORE_ACC;
            owner_host <= pick_host;
            last_host  <= pick_host;
            host_gnt   <= pick_host;
            cnt        <= CNT_LOAD;
            mem_en     <= 1'b1;
            mem_we     <= pick_host ? host_we    : core_we;
            mem_addr   <= pick_host ? host_addr  : core_addr;
            mem_wdata  <= pick_host ? host_wdata : core_wdata;
          end
        end
        CORE_ACC, HOST_ACC: begin
          if (cnt == '0) begin
            // mem_rdata is only valid in the last enabled cycle
            if (!mem_we) begin
              if (owner_host) host_rdata <= mem_rdata;
              else            core_rdata <= mem_rdata;
            end
            if (owner_host) host_done <= 1'b1;
            else            core_done <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          core_done <= 1'b0;
          host_done <= 1'b0;
          host_gnt  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus multi-cycle sequences (MEM_LAT=1 and 3).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        core_req, core_we, host_req, host_we;
  logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
  logic        core_stall, core_done, host_gnt, host_done, mem_en, mem_we;
  logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        l3_core_req, l3_core_we;
  logic [31:0] l3_core_addr, l3_core_wdata, l3_mem_rdata;
  logic        l3_core_stall, l3_core_done, l3_host_gnt, l3_host_done, l3_mem_en, l3_mem_we;
  logic [31:0] l3_core_rdata, l3_host_rdata, l3_mem_addr, l3_mem_wdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_done(core_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_done(host_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign l3_mem_rdata = 32'hCAFE_F00D;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .core_req(l3_core_req), .core_we(l3_core_we), .core_addr(l3_core_addr),
    .core_wdata(l3_core_wdata), .core_stall(l3_core_stall), .core_rdata(l3_core_rdata),
    .core_done(l3_core_done),
    .host_req(1'b0), .host_we(1'b0), .host_addr(32'h0), .host_wdata(32'h0),
    .host_gnt(l3_host_gnt), .host_rdata(l3_host_rdata), .host_done(l3_host_done),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata)
  );

  // RAM model: combinational read while enabled, word-indexed, preloaded on reset
  logic [31:0] ram [0:63];
  assign mem_rdata = mem_en ? ram[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ctl = {core_req, core_we, host_req, host_we}; flg = {stall, core_done, host_gnt, host_done, mem_en, mem_we}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] caddr, cwdata, haddr, hwdata;
    logic [5:0]  flg;
    logic [31:0] maddr, crdata, hrdata;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  logic order [4];
  int   n_done;
  int   cyc, done_cyc, en_cnt, we_cnt, first_en, stall_low, hd_seen;
  logic first_is_host;
  logic exp_host_first;

  initial begin
    rst = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    l3_core_req = 0; l3_core_we = 0; l3_core_addr = 0; l3_core_wdata = 0;

    vt[0]  = '{4'b1000, 32'h10, 32'h0, 32'h0,  32'h0,        6'b100000, 32'h0,  32'h0,        32'h0};
    vt[1]  = '{4'b1000, 32'h10, 32'h0, 32'h0,  32'h0,        6'b100010, 32'h10, 32'h0,        32'h0};
    vt[2]  = '{4'b1000, 32'h10, 32'h0, 32'h0,  32'h0,        6'b010000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[3]  = '{4'b0000, 32'h0,  32'h0, 32'h0,  32'h0,        6'b000000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[4]  = '{4'b0011, 32'h0,  32'h0, 32'h20, 32'h12345678, 6'b000000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[5]  = '{4'b0011, 32'h0,  32'h0, 32'h20, 32'h12345678, 6'b001011, 32'h20, 32'hDEADBEEF, 32'h0};
    vt[6]  = '{4'b0011, 32'h0,  32'h0, 32'h20, 32'h12345678, 6'b001100, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[7]  = '{4'b1000, 32'h20, 32'h0, 32'h0,  32'h0,        6'b100000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[8]  = '{4'b1000, 32'h20, 32'h0, 32'h0,  32'h0,        6'b100010, 32'h20, 32'hDEADBEEF, 32'h0};
    vt[9]  = '{4'b1000, 32'h20, 32'h0, 32'h0,  32'h0,        6'b010000, 32'h0,  32'h12345678, 32'h0};
    vt[10] = '{4'b0000, 32'h0,  32'h0, 32'h0,  32'h0,        6'b000000, 32'h0,  32'h12345678, 32'h0};
    vt[11] = '{4'b1000, 32'h10, 32'h0, 32'h0,  32'h0,        6'b100000, 32'h0,  32'h12345678, 32'h0};
    vt[12] = '{4'b1000, 32'h30, 32'h0, 32'h0,  32'h0,        6'b100010, 32'h10, 32'h12345678, 32'h0};
    vt[13] = '{4'b1000, 32'h30, 32'h0, 32'h0,  32'h0,        6'b010000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[14] = '{4'b0000, 32'h0,  32'h0, 32'h0,  32'h0,        6'b000000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[15] = '{4'b0010, 32'h0,  32'h0, 32'h10, 32'h0,        6'b000000, 32'h0,  32'hDEADBEEF, 32'h0};
    vt[16] = '{4'b0010, 32'h0,  32'h0, 32'h10, 32'h0,        6'b001010, 32'h10, 32'hDEADBEEF, 32'h0};
    vt[17] = '{4'b0010, 32'h0,  32'h0, 32'h10, 32'h0,        6'b001100, 32'h0,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[18] = '{4'b0000, 32'h0,  32'h0, 32'h0,  32'h0,        6'b000000, 32'h0,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[19] = '{4'b0010, 32'h0,  32'h0, 32'h20, 32'h0,        6'b000000, 32'h0,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[20] = '{4'b1010, 32'h40, 32'h0, 32'h20, 32'h0,        6'b101010, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[21] = '{4'b1010, 32'h40, 32'h0, 32'h20, 32'h0,        6'b101100, 32'h0,  32'hDEADBEEF, 32'h12345678};
    vt[22] = '{4'b1000, 32'h40, 32'h0, 32'h0,  32'h0,        6'b100000, 32'h0,  32'hDEADBEEF, 32'h12345678};
    vt[23] = '{4'b1000, 32'h40, 32'h0, 32'h0,  32'h0,        6'b100010, 32'h40, 32'hDEADBEEF, 32'h12345678};
    vt[24] = '{4'b1000, 32'h40, 32'h0, 32'h0,  32'h0,        6'b010000, 32'h0,  32'h0,        32'h12345678};
    vt[25] = '{4'b0000, 32'h0,  32'h0, 32'h0,  32'h0,        6'b000000, 32'h0,  32'h0,        32'h12345678};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst core_stall", {31'h0, core_stall}, 32'h0);
    chk("rst core_done",  {31'h0, core_done},  32'h0);
    chk("rst host_gnt",   {31'h0, host_gnt},   32'h0);
    chk("rst host_done",  {31'h0, host_done},  32'h0);
    chk("rst mem_en",     {31'h0, mem_en},     32'h0);
    chk("rst mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst mem_addr",   mem_addr,   32'h0);
    chk("rst mem_wdata",  mem_wdata,  32'h0);
    chk("rst core_rdata", core_rdata, 32'h0);
    chk("rst host_rdata", host_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single-owner traffic
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      {core_req, core_we, host_req, host_we} = vt[i].ctl;
      core_addr = vt[i].caddr; core_wdata = vt[i].cwdata;
      host_addr = vt[i].haddr; host_wdata = vt[i].hwdata;
      @(negedge clk);
      chk($sformatf("v%0d core_stall", i), {31'h0, core_stall}, {31'h0, vt[i].flg[5]});
      chk($sformatf("v%0d core_done", i),  {31'h0, core_done},  {31'h0, vt[i].flg[4]});
      chk($sformatf("v%0d host_gnt", i),   {31'h0, host_gnt},   {31'h0, vt[i].flg[3]});
      chk($sformatf("v%0d host_done", i),  {31'h0, host_done},  {31'h0, vt[i].flg[2]});
      chk($sformatf("v%0d mem_en", i),     {31'h0, mem_en},     {31'h0, vt[i].flg[1]});
      if (vt[i].flg[1]) begin
        chk($sformatf("v%0d mem_we", i),   {31'h0, mem_we},     {31'h0, vt[i].flg[0]});
        chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].maddr);
        if (vt[i].flg[0]) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].hwdata);
      end
      chk($sformatf("v%0d core_rdata", i), core_rdata, vt[i].crdata);
      chk($sformatf("v%0d host_rdata", i), host_rdata, vt[i].hrdata);
    end

    // Both requesters held from reset: grant order over four accesses
    @(posedge clk);
    #1;
    rst = 1'b0;
    core_req = 1; core_we = 0; core_addr = 32'h10;
    host_req = 1; host_we = 0; host_addr = 32'h20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0; stall_low = 0;
    for (int c = 0; c < 40 && n_done < 4; c++) begin
      @(negedge clk);
      if (!core_stall && !core_done) stall_low++;
      if (core_done && host_done) begin
        n_fail++; n_chk++;
        $display("FAIL conflict double_done: got both dones expected one");
      end
      if (core_done || host_done) begin
        order[n_done] = host_done;
        n_done++;
      end
    end
    if (n_done == 4) begin
`ifdef DMEM_ARB_HOST_PRIO_EN
      for (int k = 0; k < 4; k++) chk($sformatf("prio grant%0d is_host", k), {31'h0, order[k]}, 32'h1);
`else
      for (int k = 0; k < 4; k++) chk($sformatf("rr grant%0d is_host", k), {31'h0, order[k]}, {31'h0, k[0]});
`endif
    end else begin
      n_chk++; n_fail++;
      $display("FAIL conflict timeout: got %0d dones expected 4", n_done);
    end
    chk("conflict core stalled until own done", stall_low, 32'h0);
    core_req = 0; host_req = 0;
    repeat (2) @(posedge clk);

    // Reset asserted in the second cycle of a host read
    #1;
    host_req = 1; host_we = 0; host_addr = 32'h10;
    @(posedge clk);
    #2;
    chk("abort pre mem_en", {31'h0, mem_en}, 32'h1);
    chk("abort pre host_gnt", {31'h0, host_gnt}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort mem_en",     {31'h0, mem_en},   32'h0);
    chk("abort mem_we",     {31'h0, mem_we},   32'h0);
    chk("abort mem_addr",   mem_addr,          32'h0);
    chk("abort host_gnt",   {31'h0, host_gnt}, 32'h0);
    chk("abort host_rdata", host_rdata,        32'h0);
    chk("abort core_rdata", core_rdata,        32'h0);
    hd_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (host_done) hd_seen++;
    end
    chk("abort no host_done", hd_seen, 32'h0);
    core_req = 1; core_we = 0; core_addr = 32'h10;
    rst = 1'b1;
    n_done = 0; first_is_host = 1'b0;
    for (int c = 0; c < 10 && n_done == 0; c++) begin
      @(negedge clk);
      if (core_done || host_done) begin
        first_is_host = host_done;
        n_done = 1;
      end
    end
`ifdef DMEM_ARB_HOST_PRIO_EN
    exp_host_first = 1'b1;
`else
    exp_host_first = 1'b0;
`endif
    if (n_done == 1) chk("post-reset tie first is_host", {31'h0, first_is_host}, {31'h0, exp_host_first});
    else begin
      n_chk++; n_fail++;
      $display("FAIL post-reset tie timeout: got no done expected one");
    end
    core_req = 0; host_req = 0;

    // MEM_LAT=3 core store on the second instance
    @(posedge clk);
    #1;
    l3_core_req = 1; l3_core_we = 1; l3_core_addr = 32'h40; l3_core_wdata = 32'hA5A5A5A5;
    done_cyc = -1; en_cnt = 0; we_cnt = 0; first_en = -1;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (l3_mem_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        chk($sformatf("lat3 c%0d mem_addr", cyc), l3_mem_addr, 32'h40);
        chk($sformatf("lat3 c%0d mem_wdata", cyc), l3_mem_wdata, 32'hA5A5A5A5);
      end
      if (l3_mem_we) we_cnt++;
      if (l3_host_gnt || l3_host_done) begin
        n_chk++; n_fail++;
        $display("FAIL lat3 host activity: got gnt/done expected none");
      end
      if (l3_core_done && done_cyc < 0) begin
        done_cyc = cyc;
        chk("lat3 stall at done", {31'h0, l3_core_stall}, 32'h0);
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) l3_core_req = 0;
    end
    chk("lat3 first mem_en cycle", first_en, 32'd1);
    chk("lat3 mem_en cycles", en_cnt, 32'd3);
    chk("lat3 mem_we cycles", we_cnt, 32'd3);
    chk("lat3 core_done cycle", done_cyc, 32'd4);
    chk("lat3 core_rdata unchanged", l3_core_rdata, 32'h0);
    chk("lat3 host_rdata", l3_host_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
